// File: rtl/pipe_pkg.sv
// pipe_pkg: state encoding shared by the pipe_stage_skid slice
package pipe_pkg;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE = 2'd1;
  localparam logic [1:0] ST_TWO = 2'd2;
  typedef enum logic [1:0] {EMPTY = ST_EMPTY, ONE = ST_ONE, TWO = ST_TWO} pipe_state_t;
endpackage

// File: rtl/pipe_stage_skid_slot.sv
// pipe_slot: one pipeline entry register whose ctrl bits are zeroed whenever valid is cleared
module pipe_slot #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 2,
  parameter int WN_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ld,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  input  logic [WN_W-1:0]   d_wn,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [WN_W-1:0]   q_wn
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_ctrl <= '0;
      q_data <= '0;
      q_wn <= '0;
    end else if (clr) begin
      q_valid <= 1'b0;
      q_ctrl <= '0;
    end else if (ld) begin
      q_valid <= 1'b1;
      q_ctrl <= d_ctrl;
      q_data <= d_data;
      q_wn <= d_wn;
    end
  end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with flush, bubble-safe ctrl and optional two-entry skid
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 2,
  parameter int WN_W = 5,
  parameter int SKID = 1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [WN_W-1:0]   in_wn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [WN_W-1:0]   out_wn,
  output logic [CNT_W-1:0]  stall_cnt
);
  pipe_state_t r_state, w_next;
  logic w_acc, w_deq, w_main_ld, w_main_clr, w_skid_ld, w_skid_clr, w_skid_v;
  logic [CTRL_W-1:0] w_skid_ctrl, w_main_ctrl;
  logic [DATA_W-1:0] w_skid_data, w_main_data;
  logic [WN_W-1:0] w_skid_wn, w_main_wn;
  logic [CNT_W-1:0] r_cnt;
  assign in_ready = (SKID != 0) ? (r_state != TWO) : (~out_valid | out_ready);
  assign w_acc = in_valid & in_ready;
  assign w_deq = out_valid & out_ready;
  assign stall_cnt = r_cnt;
  always_comb begin
    w_next = flush ? EMPTY :
             (r_state == EMPTY) ? (w_acc ? ONE : EMPTY) :
             (r_state == ONE) ? ((w_acc & ~w_deq & (SKID != 0)) ? TWO : (w_deq & ~w_acc) ? EMPTY : ONE) :
             (w_deq ? ONE : TWO);
    w_main_ld = ~flush & ((r_state == TWO) ? w_deq : (w_acc & (r_state == EMPTY | w_deq)));
    w_main_clr = flush | (w_deq & ~w_main_ld);
    w_skid_ld = ~flush & (r_state == ONE) & w_acc & ~w_deq;
    w_skid_clr = flush | ((r_state == TWO) & w_deq);
    w_main_ctrl = w_skid_v ? w_skid_ctrl : in_ctrl;
    w_main_data = w_skid_v ? w_skid_data : in_data;
    w_main_wn = w_skid_v ? w_skid_wn : in_wn;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= EMPTY;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (out_valid & ~out_ready & ~&r_cnt) r_cnt <= r_cnt + CNT_W'(1);
  end
  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .WN_W(WN_W)) u_main (
    .clk(clk), .rst(rst), .clr(w_main_clr), .ld(w_main_ld),
    .d_ctrl(w_main_ctrl), .d_data(w_main_data), .d_wn(w_main_wn),
    .q_valid(out_valid), .q_ctrl(out_ctrl), .q_data(out_data), .q_wn(out_wn)
  );
  if (SKID != 0) begin : g_skid
    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .WN_W(WN_W)) u_skid (
      .clk(clk), .rst(rst), .clr(w_skid_clr), .ld(w_skid_ld),
      .d_ctrl(in_ctrl), .d_data(in_data), .d_wn(in_wn),
      .q_valid(w_skid_v), .q_ctrl(w_skid_ctrl), .q_data(w_skid_data), .q_wn(w_skid_wn)
    );
  end else begin : g_noskid
    assign w_skid_v = 1'b0;
    assign w_skid_ctrl = '0;
    assign w_skid_data = '0;
    assign w_skid_wn = '0;
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: table-driven and sequence checks of pipe_stage_skid in skid and single-entry modes
module tb_pipe_stage_skid;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] in_ctrl = '0;
  logic [15:0] in_data = '0;
  logic [4:0] in_wn = '0;
  logic r1, v1, r0, v0;
  logic [1:0] c1, c0;
  logic [15:0] d1, d0;
  logic [4:0] w1, w0;
  logic [3:0] s1;
  logic [15:0] s0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  pipe_stage_skid #(.DATA_W(16), .CTRL_W(2), .WN_W(5), .SKID(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r1),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_wn(in_wn), .out_valid(v1), .out_ready(out_ready),
    .out_ctrl(c1), .out_data(d1), .out_wn(w1), .stall_cnt(s1)
  );
  pipe_stage_skid #(.DATA_W(16), .CTRL_W(2), .WN_W(5), .SKID(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r0),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_wn(in_wn), .out_valid(v0), .out_ready(out_ready),
    .out_ctrl(c0), .out_data(d0), .out_wn(w0), .stall_cnt(s0)
  );
  typedef struct {
    logic rst, iv, orr, fl;
    logic [1:0] c;
    logic [15:0] d;
    logic ev, er;
    logic [1:0] ec;
    logic [15:0] ed;
    logic [3:0] ecnt;
    logic chk0, er0;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(input logic rst_, iv, orr, fl, input logic [1:0] c, input logic [15:0] d,
                              input logic ev, er, input logic [1:0] ec, input logic [15:0] ed,
                              input logic [3:0] ecnt, input logic chk0, er0);
    vec_t v;
    v.rst = rst_; v.iv = iv; v.orr = orr; v.fl = fl; v.c = c; v.d = d;
    v.ev = ev; v.er = er; v.ec = ec; v.ed = ed; v.ecnt = ecnt; v.chk0 = chk0; v.er0 = er0;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic ev, er, input logic [1:0] ec, input logic [15:0] ed, input logic [3:0] ecnt);
    chk({tag, " skid.out_valid"}, 32'(v1), 32'(ev));
    chk({tag, " skid.in_ready"}, 32'(r1), 32'(er));
    chk({tag, " skid.out_ctrl"}, 32'(c1), 32'(ec));
    chk({tag, " skid.out_data"}, 32'(d1), 32'(ed));
    chk({tag, " skid.out_wn"}, 32'(w1), 32'(ed[4:0]));
    chk({tag, " skid.stall_cnt"}, 32'(s1), 32'(ecnt));
  endtask
  task automatic chk0_(input string tag, input logic ev, er, input logic [1:0] ec, input logic [15:0] ed, input logic [3:0] ecnt);
    chk({tag, " single.out_valid"}, 32'(v0), 32'(ev));
    chk({tag, " single.in_ready"}, 32'(r0), 32'(er));
    chk({tag, " single.out_ctrl"}, 32'(c0), 32'(ec));
    chk({tag, " single.out_data"}, 32'(d0), 32'(ed));
    chk({tag, " single.out_wn"}, 32'(w0), 32'(ed[4:0]));
    chk({tag, " single.stall_cnt"}, 32'(s0), 32'(ecnt));
  endtask
  task automatic drive(input logic rst_, iv, orr, fl, input logic [1:0] c, input logic [15:0] d);
    rst = rst_; in_valid = iv; out_ready = orr; flush = fl; in_ctrl = c; in_data = d; in_wn = d[4:0];
  endtask
  initial begin
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 1, 1, 0, 2'b01, 16'(k + 1), k > 0, 1, (k > 0) ? 2'b01 : 2'b00, 16'(k), 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 16'h8, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h8, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 2, 16'h11, 0, 1, 0, 16'h8, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 2, 16'h12, 1, 1, 2, 16'h11, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2, 16'h13, 1, 0, 2, 16'h11, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2, 16'h13, 1, 0, 2, 16'h11, 2, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 2, 16'h13, 1, 0, 2, 16'h11, 3, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 2, 16'h13, 1, 1, 2, 16'h12, 3, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 2, 16'h13, 3, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h13, 3, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 3, 16'h21, 0, 1, 0, 16'h13, 3, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 3, 16'h22, 1, 1, 3, 16'h21, 3, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 3, 16'h23, 1, 0, 3, 16'h21, 4, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h21, 5, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h21, 5, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 3, 16'h31, 0, 1, 0, 16'h21, 5, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 3, 16'h32, 1, 1, 3, 16'h31, 5, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h31, 5, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h31, 5, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("reset", 0, 1, 0, 0, 0);
    chk0_("reset", 0, 1, 0, 0, 0);
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].iv, tbl[i].orr, tbl[i].fl, tbl[i].c, tbl[i].d);
      #1;
      chk1($sformatf("row%0d", i), tbl[i].ev, tbl[i].er, tbl[i].ec, tbl[i].ed, tbl[i].ecnt);
      if (tbl[i].chk0) chk0_($sformatf("row%0d", i), tbl[i].ev, tbl[i].er0, tbl[i].ec, tbl[i].ed, tbl[i].ecnt);
    end
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk1("sat_rst", 0, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 0, 0, 1, 16'h51);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("sat_cnt%0d", i), 32'(s1), (i < 15) ? i : 15);
    end
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0);
    #1;
    chk("sat_cnt20", 32'(s1), 15);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk1("sat_flush", 0, 1, 0, 16'h51, 15);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk1("sat_clear", 0, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 0, 0, 1, 16'h41);
    #1;
    chk("mid_pre.valid", 32'(v1), 0);
    @(negedge clk);
    drive(1, 1, 0, 0, 2, 16'h42);
    #1;
    chk1("mid_one", 1, 1, 1, 16'h41, 0);
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 0);
    #1;
    chk1("mid_rst", 0, 1, 0, 0, 0);
    @(negedge clk);
    #1;
    chk1("mid_after", 0, 1, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
